param_control_unit: RTL and testbench
=====================================

Name: param_control_unit

Overview:
- Multicycle control FSM for the 8-bit-class accumulator/register CPU datapath.
- Decodes the instruction register and drives register loads, bus mux selects, PC and memory control.
- Successor to the fixed 4-register controller. Register count and word width are parametrised.
- New behaviour:
  - memory wait-state handshake;
  - explicit HLT opcode;
  - NOT executed in the EXEC cycle;
  - sticky error reporting.

Parameters:
- WORD_SIZE, 8, instruction/data word width.
- OPCODE_SIZE, 4, opcode field width (top bits of the instruction).
- NUM_REGS, 4, general registers; power of 2, >=2.
- REG_AW, $clog2(NUM_REGS), src/dst field width.
- Constraint: OPCODE_SIZE + 2*REG_AW <= WORD_SIZE. Elaboration error otherwise.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-low reset.
- instruction  input  WORD_SIZE  IR contents. Fields: opcode = [WORD_SIZE-1 -: OPCODE_SIZE], src = [2*REG_AW-1 : REG_AW], dst = [REG_AW-1:0].
- zero  input  1  Z flag from the flag register.
- mem_ready  input  1  memory completes the current access this cycle.
- load_reg  output  NUM_REGS  one-hot register load enable.
- load_z, load_y, load_ir, load_addr_reg, load_pc, inc_pc  output  1 each  datapath strobes.
- write  output  1  memory write strobe.
- mem_req  output  1  memory access in progress.
- sel_bus_1_mux  output  REG_AW+1  bus1 source; 0..NUM_REGS-1 = register, NUM_REGS = PC.
- sel_bus_2_mux  output  2  bus2 source; 0 = ALU, 1 = bus1, 2 = memory, 3 = reserved.
- alu_op  output  OPCODE_SIZE  opcode passed to the ALU during EXEC, else 0.
- halted  output  1  FSM in HALT.
- err  output  1  sticky error.

Behaviour:
- State register updates on posedge clk; rst low forces IDLE asynchronously and clears err.
- All other outputs are combinational from state, instruction, zero and mem_ready.
- Default for every output is 0. Therefore every output is 0 during and immediately after reset.
- Opcodes: NOP=0, ADD=1, SUB=2, AND=3, NOT=4, RD=5, WR=6, BR=7, BRZ=8, HLT=9. Values 10..2^OPCODE_SIZE-1 are illegal.
- States: IDLE, FET1, FET2, DEC, EXEC, RD1, RD2, WR1, WR2, BR1, BR2, HALT.
- IDLE -> FET1 unconditionally.
- FET1: sel_bus_1_mux=NUM_REGS, sel_bus_2_mux=1, load_addr_reg -> FET2.
- FET2: mem_req, sel_bus_2_mux=2.
  - Stays in FET2 while mem_ready=0, with no strobes.
  - When mem_ready=1: load_ir, inc_pc -> DEC.
- DEC, by opcode:
  - NOP -> FET1.
  - ADD/SUB/AND/NOT: sel_bus_1_mux=src, sel_bus_2_mux=1, load_y -> EXEC.
  - RD/WR/BR: PC to address register (as FET1) -> RD1/WR1/BR1.
  - BRZ with zero=1: as BR -> BR1.
  - BRZ with zero=0: inc_pc (skips the address word) -> FET1.
  - HLT -> HALT.
  - Illegal opcode: set err -> HALT.
- EXEC: alu_op=opcode, sel_bus_2_mux=0, load_z, load_reg[dst]=1 -> FET1. NOT also completes here.
- RD1/WR1/BR1: mem_req, sel_bus_2_mux=2; wait on mem_ready.
  - On ready: load_addr_reg.
  - RD1/WR1 also assert inc_pc; BR1 does not.
  - Next state: RD2/WR2/BR2.
- RD2: mem_req, sel_bus_2_mux=2; on ready load_reg[dst] -> FET1.
- WR2: mem_req, sel_bus_1_mux=src, sel_bus_2_mux=1, write=1 held until mem_ready -> FET1.
- BR2: mem_req, sel_bus_2_mux=2; on ready load_pc -> FET1.
- HALT: absorbing; halted=1. Only reset exits.
- Unreachable state encoding: set err, go to IDLE.
- Strobes that complete an access are asserted only in the mem_ready=1 cycle. The exception is write, which is level-held.
- Reset mid-access: FSM returns to IDLE, and mem_req deasserts asynchronously.

Optional Feature:
- Macro CU_SINGLE_STEP_EN.
- When defined, adds input step (1 bit). FSM holds in FET1 with all outputs 0 until step=1, then performs the normal FET1 action. Exactly one instruction executes per step pulse.
- When undefined, the port is absent and FET1 never stalls.

Decomposition:
- Package cu_pkg holds:
  - opcode localparams;
  - state enum/localparams (4-bit encoding);
  - sel_bus_2_mux encodings;
  - field-extract width functions.
- One natural sub-module: cu_reg_decode, a REG_AW -> NUM_REGS one-hot decoder with enable. It is used for load_reg.

Test Plan:
- Reset, then ADD r1,r2 with NUM_REGS=4, mem_ready tied 1 -> IDLE, FET1, FET2, DEC, EXEC. In DEC: sel_bus_1_mux=2, load_y=1. In EXEC: load_reg=4'b0010, load_z=1, alu_op=1.
- RD r3 with mem_ready low 2 cycles in each of FET2, RD1 and RD2 -> each state holds 3 cycles. load_reg=4'b1000 only in the final RD2 ready cycle.
- BRZ with zero=0 -> DEC asserts inc_pc, next state FET1. With zero=1 -> BR1, BR2, and load_pc pulses once.
- WR r0 with mem_ready=0 for 3 cycles in WR2 -> write=1 for 4 cycles, sel_bus_1_mux=0 throughout.
- Opcode 4'hC -> err=1 and halted=1 after DEC. rst pulse -> err=0, state IDLE.
- NUM_REGS=8, WORD_SIZE=12: NOT r7 -> r5 -> load_reg=8'b00100000 in EXEC. With CU_SINGLE_STEP_EN, no FET2 occurs until step pulses.

Source files
------------

// File: rtl/param_control_unit_pkg.sv
// rtl/param_control_unit_pkg.sv - opcodes, FSM state encoding, bus2 selects and field helpers for the control unit
package cu_pkg;

  // Instruction opcodes; anything at or above NUM_LEGAL_OPS is illegal.
  localparam int OP_NOP = 0;
  localparam int OP_ADD = 1;
  localparam int OP_SUB = 2;
  localparam int OP_AND = 3;
  localparam int OP_NOT = 4;
  localparam int OP_RD  = 5;
  localparam int OP_WR  = 6;
  localparam int OP_BR  = 7;
  localparam int OP_BRZ = 8;
  localparam int OP_HLT = 9;
  localparam int NUM_LEGAL_OPS = 10;

  // Controller states; codes 12..15 are unreachable and trap to IDLE with err.
  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_FET1 = 4'd1,
    S_FET2 = 4'd2,
    S_DEC  = 4'd3,
    S_EXEC = 4'd4,
    S_RD1  = 4'd5,
    S_RD2  = 4'd6,
    S_WR1  = 4'd7,
    S_WR2  = 4'd8,
    S_BR1  = 4'd9,
    S_BR2  = 4'd10,
    S_HALT = 4'd11
  } state_t;

  // bus2 source selects (code 3 is reserved and never driven).
  localparam logic [1:0] BUS2_ALU  = 2'd0;
  localparam logic [1:0] BUS2_BUS1 = 2'd1;
  localparam logic [1:0] BUS2_MEM  = 2'd2;

  // Width of the src/dst register fields for a given register count.
  function automatic int reg_field_w(input int num_regs);
    return (num_regs > 1) ? $clog2(num_regs) : 1;
  endfunction

  // Bit position of the opcode field LSB within the instruction word.
  function automatic int opcode_lsb(input int word_size, input int opcode_size);
    return word_size - opcode_size;
  endfunction

endpackage

// File: rtl/param_control_unit_if.sv
// rtl/param_control_unit_if.sv - control unit <-> datapath bundle; step exists only with CU_SINGLE_STEP_EN
interface param_control_unit_if #(
  parameter int WORD_SIZE   = 8,
  parameter int OPCODE_SIZE = 4,
  parameter int NUM_REGS    = 4,
  parameter int REG_AW      = $clog2(NUM_REGS)
);
  logic [WORD_SIZE-1:0]   instruction;
  logic                   zero;
  logic                   mem_ready;
`ifdef CU_SINGLE_STEP_EN
  logic                   step;
`endif
  logic [NUM_REGS-1:0]    load_reg;
  logic                   load_z;
  logic                   load_y;
  logic                   load_ir;
  logic                   load_addr_reg;
  logic                   load_pc;
  logic                   inc_pc;
  logic                   write;
  logic                   mem_req;
  logic [REG_AW:0]        sel_bus_1_mux;
  logic [1:0]             sel_bus_2_mux;
  logic [OPCODE_SIZE-1:0] alu_op;
  logic                   halted;
  logic                   err;

  modport master (
`ifdef CU_SINGLE_STEP_EN
    input  step,
`endif
    input  instruction, zero, mem_ready,
    output load_reg, load_z, load_y, load_ir, load_addr_reg, load_pc, inc_pc,
    output write, mem_req, sel_bus_1_mux, sel_bus_2_mux, alu_op, halted, err
  );

  modport slave (
`ifdef CU_SINGLE_STEP_EN
    output step,
`endif
    output instruction, zero, mem_ready,
    input  load_reg, load_z, load_y, load_ir, load_addr_reg, load_pc, inc_pc,
    input  write, mem_req, sel_bus_1_mux, sel_bus_2_mux, alu_op, halted, err
  );
endinterface

// File: rtl/param_control_unit_reg_decode.sv
// rtl/param_control_unit_reg_decode.sv - register index to one-hot load enable decoder
module cu_reg_decode #(
  parameter int NUM_REGS = 4,
  parameter int REG_AW   = 2
) (
  input  logic              en,
  input  logic [REG_AW-1:0] idx,
  output logic [NUM_REGS-1:0] onehot
);

  // One bit per register, all low unless enabled.
  always_comb begin
    onehot = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (en && (idx == REG_AW'(i))) onehot[i] = 1'b1;
    end
  end

endmodule

// File: rtl/param_control_unit.sv
// rtl/param_control_unit.sv - multicycle CPU control FSM; optional single-step fetch gate via CU_SINGLE_STEP_EN
module param_control_unit
  import cu_pkg::*;
#(
  parameter int WORD_SIZE   = 8,
  parameter int OPCODE_SIZE = 4,
  parameter int NUM_REGS    = 4,
  parameter int REG_AW      = $clog2(NUM_REGS)
) (
  input logic clk,
  input logic rst,
  param_control_unit_if.master cu
);

  localparam int OP_LSB = opcode_lsb(WORD_SIZE, OPCODE_SIZE);
  localparam logic [REG_AW:0] SEL1_PC = (REG_AW + 1)'(NUM_REGS);

  localparam logic [OPCODE_SIZE-1:0] OPC_NOP = OPCODE_SIZE'(OP_NOP);
  localparam logic [OPCODE_SIZE-1:0] OPC_ADD = OPCODE_SIZE'(OP_ADD);
  localparam logic [OPCODE_SIZE-1:0] OPC_SUB = OPCODE_SIZE'(OP_SUB);
  localparam logic [OPCODE_SIZE-1:0] OPC_AND = OPCODE_SIZE'(OP_AND);
  localparam logic [OPCODE_SIZE-1:0] OPC_NOT = OPCODE_SIZE'(OP_NOT);
  localparam logic [OPCODE_SIZE-1:0] OPC_RD  = OPCODE_SIZE'(OP_RD);
  localparam logic [OPCODE_SIZE-1:0] OPC_WR  = OPCODE_SIZE'(OP_WR);
  localparam logic [OPCODE_SIZE-1:0] OPC_BR  = OPCODE_SIZE'(OP_BR);
  localparam logic [OPCODE_SIZE-1:0] OPC_BRZ = OPCODE_SIZE'(OP_BRZ);
  localparam logic [OPCODE_SIZE-1:0] OPC_HLT = OPCODE_SIZE'(OP_HLT);

  generate
    if (OPCODE_SIZE + 2 * REG_AW > WORD_SIZE)
      $error("param_control_unit: opcode and register fields do not fit in WORD_SIZE");
    if ((NUM_REGS < 2) || ((NUM_REGS & (NUM_REGS - 1)) != 0))
      $error("param_control_unit: NUM_REGS must be a power of 2 and at least 2");
    if (REG_AW != reg_field_w(NUM_REGS))
      $error("param_control_unit: REG_AW must equal clog2(NUM_REGS)");
    if (OPCODE_SIZE < 4)
      $error("param_control_unit: OPCODE_SIZE too small for the opcode set");
    if (NUM_LEGAL_OPS > (1 << OPCODE_SIZE))
      $error("param_control_unit: opcode field cannot hold every legal opcode");
  endgenerate

  state_t state_q, state_d;
  logic   err_q, err_d;

  logic [OPCODE_SIZE-1:0] opcode;
  logic [REG_AW-1:0]      src;
  logic [REG_AW-1:0]      dst;
  logic                   fetch_go;
  logic                   unused_fields;

  logic                   reg_ld_en;
  logic [NUM_REGS-1:0]    load_reg_oh;
  logic                   addr_from_pc;
  logic                   load_z, load_y, load_ir, load_addr_reg, load_pc, inc_pc;
  logic                   write, mem_req, halted;
  logic [REG_AW:0]        sel_bus_1;
  logic [1:0]             sel_bus_2;
  logic [OPCODE_SIZE-1:0] alu_op;

  assign opcode = cu.instruction[OP_LSB +: OPCODE_SIZE];
  assign src    = cu.instruction[2*REG_AW-1 -: REG_AW];
  assign dst    = cu.instruction[REG_AW-1:0];
  // Wider words leave gap bits between the fields that nothing decodes.
  assign unused_fields = ^cu.instruction;

`ifdef CU_SINGLE_STEP_EN
  assign fetch_go = cu.step;
`else
  assign fetch_go = 1'b1;
`endif

  // State and sticky error registers; reset lands in IDLE with err clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  // Next-state and datapath strobe decode; completion strobes wait for mem_ready.
  always_comb begin
    state_d       = state_q;
    err_d         = err_q;
    reg_ld_en     = 1'b0;
    addr_from_pc  = 1'b0;
    load_z        = 1'b0;
    load_y        = 1'b0;
    load_ir       = 1'b0;
    load_addr_reg = 1'b0;
    load_pc       = 1'b0;
    inc_pc        = 1'b0;
    write         = 1'b0;
    mem_req       = 1'b0;
    halted        = 1'b0;
    sel_bus_1     = '0;
    sel_bus_2     = BUS2_ALU;
    alu_op        = '0;

    case (state_q)
      S_IDLE: state_d = S_FET1;

      S_FET1: begin
        if (fetch_go) begin
          addr_from_pc = 1'b1;
          state_d      = S_FET2;
        end
      end

      S_FET2: begin
        mem_req   = 1'b1;
        sel_bus_2 = BUS2_MEM;
        if (cu.mem_ready) begin
          load_ir = 1'b1;
          inc_pc  = 1'b1;
          state_d = S_DEC;
        end
      end

      S_DEC: begin
        case (opcode)
          OPC_NOP: state_d = S_FET1;
          OPC_ADD, OPC_SUB, OPC_AND, OPC_NOT: begin
            sel_bus_1 = {1'b0, src};
            sel_bus_2 = BUS2_BUS1;
            load_y    = 1'b1;
            state_d   = S_EXEC;
          end
          OPC_RD: begin
            addr_from_pc = 1'b1;
            state_d      = S_RD1;
          end
          OPC_WR: begin
            addr_from_pc = 1'b1;
            state_d      = S_WR1;
          end
          OPC_BR: begin
            addr_from_pc = 1'b1;
            state_d      = S_BR1;
          end
          OPC_BRZ: begin
            if (cu.zero) begin
              addr_from_pc = 1'b1;
              state_d      = S_BR1;
            end else begin
              // Branch not taken: step the PC over the target address word.
              inc_pc  = 1'b1;
              state_d = S_FET1;
            end
          end
          OPC_HLT: state_d = S_HALT;
          default: begin
            err_d   = 1'b1;
            state_d = S_HALT;
          end
        endcase
      end

      S_EXEC: begin
        alu_op    = opcode;
        sel_bus_2 = BUS2_ALU;
        load_z    = 1'b1;
        reg_ld_en = 1'b1;
        state_d   = S_FET1;
      end

      S_RD1, S_WR1, S_BR1: begin
        mem_req   = 1'b1;
        sel_bus_2 = BUS2_MEM;
        if (cu.mem_ready) begin
          load_addr_reg = 1'b1;
          // Branch targets replace the PC, so only RD/WR advance past the address word.
          inc_pc = (state_q != S_BR1);
          case (state_q)
            S_RD1:   state_d = S_RD2;
            S_WR1:   state_d = S_WR2;
            default: state_d = S_BR2;
          endcase
        end
      end

      S_RD2: begin
        mem_req   = 1'b1;
        sel_bus_2 = BUS2_MEM;
        if (cu.mem_ready) begin
          reg_ld_en = 1'b1;
          state_d   = S_FET1;
        end
      end

      S_WR2: begin
        // write is held for the whole access, not just the ready cycle.
        mem_req   = 1'b1;
        sel_bus_1 = {1'b0, src};
        sel_bus_2 = BUS2_BUS1;
        write     = 1'b1;
        if (cu.mem_ready) state_d = S_FET1;
      end

      S_BR2: begin
        mem_req   = 1'b1;
        sel_bus_2 = BUS2_MEM;
        if (cu.mem_ready) begin
          load_pc = 1'b1;
          state_d = S_FET1;
        end
      end

      S_HALT: halted = 1'b1;

      default: begin
        err_d   = 1'b1;
        state_d = S_IDLE;
      end
    endcase

    if (addr_from_pc) begin
      sel_bus_1     = SEL1_PC;
      sel_bus_2     = BUS2_BUS1;
      load_addr_reg = 1'b1;
    end
  end

  cu_reg_decode #(
    .NUM_REGS (NUM_REGS),
    .REG_AW   (REG_AW)
  ) u_reg_decode (
    .en     (reg_ld_en),
    .idx    (dst),
    .onehot (load_reg_oh)
  );

  assign cu.load_reg      = load_reg_oh;
  assign cu.load_z        = load_z;
  assign cu.load_y        = load_y;
  assign cu.load_ir       = load_ir;
  assign cu.load_addr_reg = load_addr_reg;
  assign cu.load_pc       = load_pc;
  assign cu.inc_pc        = inc_pc;
  assign cu.write         = write;
  assign cu.mem_req       = mem_req;
  assign cu.sel_bus_1_mux = sel_bus_1;
  assign cu.sel_bus_2_mux = sel_bus_2;
  assign cu.alu_op        = alu_op;
  assign cu.halted        = halted;
  assign cu.err           = err_q;

endmodule

// File: tb/tb_param_control_unit.sv
// tb/tb_param_control_unit.sv - directed bench with micro-op queue model; CU_SINGLE_STEP_EN adds a step-gate test
`timescale 1ns/1ps
module tb_param_control_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  param_control_unit_if #(.WORD_SIZE(8),  .OPCODE_SIZE(4), .NUM_REGS(4)) bus4 ();
  param_control_unit_if #(.WORD_SIZE(12), .OPCODE_SIZE(4), .NUM_REGS(8)) bus8 ();

  param_control_unit #(.WORD_SIZE(8), .OPCODE_SIZE(4), .NUM_REGS(4)) dut4 (
    .clk (clk), .rst (rst), .cu (bus4)
  );
  param_control_unit #(.WORD_SIZE(12), .OPCODE_SIZE(4), .NUM_REGS(8)) dut8 (
    .clk (clk), .rst (rst), .cu (bus8)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each instruction is a list of micro-operations; one is consumed per completed cycle.
  localparam int U_IDLE = 0, U_PCADDR = 1, U_IRFETCH = 2, U_DECODE = 3, U_ALU = 4;
  localparam int U_ADDRW = 5, U_ADDRW_NI = 6, U_LOAD = 7, U_STORE = 8, U_JUMP = 9, U_HALT = 10;

  int   uq[$];
  logic m_err = 1'b0;
  int   op, opc, src, dst;
  bit   done, new_err, step_ok;
  logic [3:0] e_lreg;
  logic [2:0] e_s1;
  logic [1:0] e_s2;
  logic [3:0] e_alu;
  logic e_lz, e_ly, e_lir, e_laddr, e_lpc, e_inc, e_wr, e_req, e_halt;

  always @(negedge clk) begin
    e_lreg = '0; e_s1 = '0; e_s2 = '0; e_alu = '0;
    e_lz = 0; e_ly = 0; e_lir = 0; e_laddr = 0; e_lpc = 0; e_inc = 0; e_wr = 0; e_req = 0; e_halt = 0;
    done = 1; new_err = 0;
    opc = int'(bus4.instruction[7:4]);
    src = int'(bus4.instruction[3:2]);
    dst = int'(bus4.instruction[1:0]);
`ifdef CU_SINGLE_STEP_EN
    step_ok = bus4.step;
`else
    step_ok = 1;
`endif
    if (!rst) begin
      uq.delete();
      uq.push_back(U_IDLE);
      m_err = 0;
      done = 0;
    end else begin
      if (uq.size() == 0) begin
        uq.push_back(U_PCADDR);
        uq.push_back(U_IRFETCH);
        uq.push_back(U_DECODE);
      end
      op = uq[0];
      case (op)
        U_IDLE: ;
        U_PCADDR: begin
          if (step_ok) begin e_s1 = 3'd4; e_s2 = 2'd1; e_laddr = 1; end
          else done = 0;
        end
        U_IRFETCH: begin
          e_req = 1; e_s2 = 2'd2;
          if (bus4.mem_ready) begin e_lir = 1; e_inc = 1; end else done = 0;
        end
        U_DECODE: begin
          if (opc >= 1 && opc <= 4) begin
            e_s1 = 3'(src); e_s2 = 2'd1; e_ly = 1;
            uq.push_back(U_ALU);
          end else if (opc == 5 || opc == 6 || opc == 7 || (opc == 8 && bus4.zero)) begin
            e_s1 = 3'd4; e_s2 = 2'd1; e_laddr = 1;
            uq.push_back((opc == 5 || opc == 6) ? U_ADDRW : U_ADDRW_NI);
            uq.push_back(opc == 5 ? U_LOAD : (opc == 6 ? U_STORE : U_JUMP));
          end else if (opc == 8) begin
            e_inc = 1;
          end else if (opc == 9) begin
            uq.push_back(U_HALT);
          end else if (opc >= 10) begin
            new_err = 1;
            uq.push_back(U_HALT);
          end
        end
        U_ALU: begin
          e_alu = 4'(opc); e_s2 = 2'd0; e_lz = 1; e_lreg = 4'b0001 << dst;
        end
        U_ADDRW, U_ADDRW_NI: begin
          e_req = 1; e_s2 = 2'd2;
          if (bus4.mem_ready) begin e_laddr = 1; e_inc = (op == U_ADDRW); end else done = 0;
        end
        U_LOAD: begin
          e_req = 1; e_s2 = 2'd2;
          if (bus4.mem_ready) e_lreg = 4'b0001 << dst; else done = 0;
        end
        U_STORE: begin
          e_req = 1; e_s1 = 3'(src); e_s2 = 2'd1; e_wr = 1;
          if (!bus4.mem_ready) done = 0;
        end
        U_JUMP: begin
          e_req = 1; e_s2 = 2'd2;
          if (bus4.mem_ready) e_lpc = 1; else done = 0;
        end
        default: begin
          e_halt = 1; done = 0;
        end
      endcase
    end
    chk("m_load_reg", bus4.load_reg, e_lreg);
    chk("m_load_z", bus4.load_z, e_lz);
    chk("m_load_y", bus4.load_y, e_ly);
    chk("m_load_ir", bus4.load_ir, e_lir);
    chk("m_load_addr_reg", bus4.load_addr_reg, e_laddr);
    chk("m_load_pc", bus4.load_pc, e_lpc);
    chk("m_inc_pc", bus4.inc_pc, e_inc);
    chk("m_write", bus4.write, e_wr);
    chk("m_mem_req", bus4.mem_req, e_req);
    chk("m_sel_bus_1_mux", bus4.sel_bus_1_mux, e_s1);
    chk("m_sel_bus_2_mux", bus4.sel_bus_2_mux, e_s2);
    chk("m_alu_op", bus4.alu_op, e_alu);
    chk("m_halted", bus4.halted, e_halt);
    chk("m_err", bus4.err, m_err);
    if (new_err) m_err = 1;
    if (done) void'(uq.pop_front());
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst = 1'b1;
    bus4.instruction = 8'h19; bus4.zero = 1'b0; bus4.mem_ready = 1'b1;
    bus8.instruction = 12'h43D; bus8.zero = 1'b0; bus8.mem_ready = 1'b1;
`ifdef CU_SINGLE_STEP_EN
    bus4.step = 1'b1;
    bus8.step = 1'b1;
`endif
    #2 rst = 1'b0;
    #1;
    chk("rst_load_addr_reg", bus4.load_addr_reg, 0);
    chk("rst_mem_req", bus4.mem_req, 0);
    chk("rst_sel1", bus4.sel_bus_1_mux, 0);
    chk("rst_err", bus4.err, 0);
    chk("rst_load_reg8", bus8.load_reg, 0);
    nxt(); nxt();
    rst = 1'b1;

    // ADD r1,r2 on the 4-reg unit, NOT r7->r5 on the 8-reg unit, in lockstep
    settle(); chk("add_idle_laddr", bus4.load_addr_reg, 0);
    nxt(); settle();
    chk("add_fet1_laddr", bus4.load_addr_reg, 1);
    chk("add_fet1_sel1", bus4.sel_bus_1_mux, 4);
    chk("not8_fet1_sel1", bus8.sel_bus_1_mux, 8);
    nxt(); settle();
    chk("add_fet2_load_ir", bus4.load_ir, 1);
    chk("add_fet2_inc_pc", bus4.inc_pc, 1);
    nxt(); settle();
    chk("add_dec_sel1", bus4.sel_bus_1_mux, 2);
    chk("add_dec_load_y", bus4.load_y, 1);
    chk("not8_dec_sel1", bus8.sel_bus_1_mux, 7);
    nxt(); settle();
    chk("add_exec_load_reg", bus4.load_reg, 4'b0010);
    chk("add_exec_load_z", bus4.load_z, 1);
    chk("add_exec_alu_op", bus4.alu_op, 1);
    chk("not8_exec_load_reg", bus8.load_reg, 8'b0010_0000);
    chk("not8_exec_alu_op", bus8.alu_op, 4);
    nxt();

    // NOP: FET1, FET2, DEC, back to FET1
    bus4.instruction = 8'h00;
    nxt(); nxt(); nxt();

    // RD r3 with two wait cycles in FET2, RD1 and RD2
    bus4.instruction = 8'h53;
    nxt();
    for (int i = 0; i < 2; i++) begin
      bus4.mem_ready = 1'b0; settle();
      chk("rd_fet2_wait_load_ir", bus4.load_ir, 0);
      nxt();
    end
    bus4.mem_ready = 1'b1; settle(); chk("rd_fet2_load_ir", bus4.load_ir, 1);
    nxt(); nxt();
    for (int i = 0; i < 2; i++) begin
      bus4.mem_ready = 1'b0; nxt();
    end
    bus4.mem_ready = 1'b1; settle(); chk("rd1_inc_pc", bus4.inc_pc, 1);
    nxt();
    for (int i = 0; i < 2; i++) begin
      bus4.mem_ready = 1'b0; settle();
      chk("rd2_wait_load_reg", bus4.load_reg, 0);
      nxt();
    end
    bus4.mem_ready = 1'b1; settle(); chk("rd2_load_reg", bus4.load_reg, 4'b1000);
    nxt();

    // BRZ not taken, then taken
    bus4.instruction = 8'h80; bus4.zero = 1'b0;
    nxt(); nxt(); settle();
    chk("brz0_dec_inc_pc", bus4.inc_pc, 1);
    chk("brz0_dec_laddr", bus4.load_addr_reg, 0);
    nxt(); settle();
    chk("brz0_next_fet1", bus4.load_addr_reg, 1);
    bus4.zero = 1'b1;
    nxt(); nxt(); settle();
    chk("brz1_dec_laddr", bus4.load_addr_reg, 1);
    chk("brz1_dec_inc_pc", bus4.inc_pc, 0);
    nxt(); settle();
    chk("brz1_br1_inc_pc", bus4.inc_pc, 0);
    nxt(); settle();
    chk("brz1_br2_load_pc", bus4.load_pc, 1);
    nxt(); settle();
    chk("brz1_after_load_pc", bus4.load_pc, 0);

    // WR r0 with three wait cycles in WR2
    bus4.instruction = 8'h60; bus4.zero = 1'b0;
    nxt(); nxt(); nxt(); nxt();
    for (int i = 0; i < 4; i++) begin
      bus4.mem_ready = (i == 3); settle();
      chk("wr2_write", bus4.write, 1);
      chk("wr2_sel1", bus4.sel_bus_1_mux, 0);
      nxt();
    end
    settle(); chk("wr_done_write", bus4.write, 0);

    // Reset in the middle of an instruction fetch drops mem_req at once
    nxt(); bus4.mem_ready = 1'b0; settle();
    chk("mid_rst_req_before", bus4.mem_req, 1);
    rst = 1'b0; settle();
    chk("mid_rst_req_after", bus4.mem_req, 0);
    nxt(); rst = 1'b1; bus4.mem_ready = 1'b1;

    // HLT parks the FSM without error
    bus4.instruction = 8'h90;
    nxt(); nxt(); nxt(); nxt(); settle();
    chk("hlt_halted", bus4.halted, 1);
    chk("hlt_err", bus4.err, 0);
    nxt(); settle(); chk("hlt_stays", bus4.halted, 1);
    rst = 1'b0; settle(); chk("hlt_rst_halted", bus4.halted, 0);
    nxt(); rst = 1'b1;

    // Illegal opcode 4'hC sets sticky err and halts; reset clears it
    bus4.instruction = 8'hC0;
    nxt(); nxt(); nxt(); settle();
    chk("ill_dec_err", bus4.err, 0);
    nxt(); settle();
    chk("ill_err", bus4.err, 1);
    chk("ill_halted", bus4.halted, 1);
    nxt(); settle(); chk("ill_err_sticky", bus4.err, 1);
    rst = 1'b0; settle();
    chk("ill_rst_err", bus4.err, 0);
    chk("ill_rst_halted", bus4.halted, 0);
    nxt(); rst = 1'b1; bus4.instruction = 8'h00;
    settle(); chk("ill_rst_idle", bus4.load_addr_reg, 0);
    nxt(); settle(); chk("ill_rst_fet1", bus4.load_addr_reg, 1);

`ifdef CU_SINGLE_STEP_EN
    // FET1 stalls with everything low until step is raised
    nxt(); nxt(); nxt();
    bus4.step = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("step_stall_laddr", bus4.load_addr_reg, 0);
      nxt();
    end
    bus4.step = 1'b1; settle(); chk("step_go_laddr", bus4.load_addr_reg, 1);
    nxt(); bus4.step = 1'b0; settle(); chk("step_fet2_req", bus4.mem_req, 1);
    nxt(); nxt(); settle(); chk("step_next_stall", bus4.load_addr_reg, 0);
    nxt(); settle(); chk("step_still_stall", bus4.mem_req, 0);
`endif

    nxt(); nxt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
